// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the I-cache, D-cache and backing-memory signals of mem_arbiter.
//   I-cache  : i_req, i_addr -> i_rdata, i_rvalid, i_done
//   D-cache  : d_req, d_we, d_addr, d_wdata -> d_wready, d_rdata, d_rvalid, d_done
//   Memory   : mem_req, mem_we, mem_addr, mem_wdata -> mem_ack, mem_rdata
//   Status   : busy, owner
// master = arbiter side, slave = caches/memory side.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_done;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_wready;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_done;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        busy;
    logic        owner;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_rdata, i_rvalid, i_done, d_wready, d_rdata, d_rvalid, d_done,
               mem_req, mem_we, mem_addr, mem_wdata, busy, owner
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_rdata, i_rvalid, i_done, d_wready, d_rdata, d_rvalid, d_done,
               mem_req, mem_we, mem_addr, mem_wdata, busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter letting an I-cache and a D-cache share one
// backing memory for BLOCK_WORDS-beat bursts (refill reads, D writebacks).
//   clock : single rising-edge clock
//   reset : synchronous, active-high
//   bus   : mem_arbiter_if.master carrying cache, memory and status signals
// Beat-level responses (rvalid/rdata/wready) follow mem_ack in the same cycle,
// so they are combinational from the registered state and the memory inputs.
module mem_arbiter #(
    parameter int unsigned BLOCK_WORDS = 4
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    localparam int unsigned BEAT_W    = $clog2(BLOCK_WORDS);
    localparam logic [31:0] BASE_MASK = ~32'((BLOCK_WORDS * 4) - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q,  beat_d;
    logic              owner_q, owner_d;   // doubles as the round-robin last-grant
    logic              we_q,    we_d;
    logic [31:0]       base_q,  base_d;
    logic              grant_dcache;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            base_q  <= base_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        owner_d      = owner_q;
        we_d         = we_q;
        base_d       = base_q;
        grant_dcache = 1'b0;

        bus.i_rdata   = '0;
        bus.i_rvalid  = 1'b0;
        bus.i_done    = 1'b0;
        bus.d_wready  = 1'b0;
        bus.d_rdata   = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_done    = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.busy      = (state_q != ST_IDLE);
        bus.owner     = owner_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // On a tie the side not granted last wins
                    grant_dcache = bus.d_req && (!bus.i_req || !owner_q);
                    owner_d      = grant_dcache;
                    we_d         = grant_dcache && bus.d_we;
                    base_d       = (grant_dcache ? bus.d_addr : bus.i_addr) & BASE_MASK;
                    beat_d       = '0;
                    state_d      = ST_BURST;
                end
            end

            ST_BURST: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = base_q + 32'({beat_q, 2'b00});
                bus.mem_wdata = we_q ? bus.d_wdata : '0;
                if (bus.mem_ack) begin
                    if (we_q) begin
                        bus.d_wready = 1'b1;
                    end else if (owner_q) begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = bus.mem_rdata;
                    end else begin
                        bus.i_rvalid = 1'b1;
                        bus.i_rdata  = bus.mem_rdata;
                    end
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                bus.i_done = !owner_q;
                bus.d_done = owner_q;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule
